iob_clint_rtc_tick: RTL and testbench

Timebase tick generator that drives the `mtime` increment of `iob_clint`. It synchronizes an asynchronous external real-time-clock input, detects rising edges, and issues one-cycle `tick_o` pulses in the `clk_i` domain. As an alternative source, it divides `clk_i` by a programmable ratio. A watchdog flags a stalled external RTC.

---
 rtl/iob_clint_rtc_tick.sv | 189 ++++++++++++++++++
 tb/tb_iob_clint_rtc_tick.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_clint_rtc_tick.sv
// -----------------------------------------------------------------------------
// iob_clint_rtc_tick
//
// Produces the timebase tick that advances mtime in iob_clint. It uses one of
// two sources:
//   - external: an asynchronous RTC square wave. The wave is synchronized,
//     optionally glitch-filtered and edge-detected, and every rising edge gives
//     one tick.
//   - internal: clk_i divided by a programmable ratio.
// A watchdog raises a sticky flag when the external RTC stops toggling.
//
// Optional feature macro: IOB_CLINT_RTC_FILTER_EN
//   defined   -> a FILT_LEN-cycle glitch filter sits after the synchronizer
//   undefined -> no filter logic, and FILT_LEN is only range-checked
//
// Ports
//   clk_i       in   system clock
//   arst_n_i    in   asynchronous active-low reset
//   en_i        in   block enable
//   src_sel_i   in   0 = external rtc_i, 1 = internal divider
//   div_i       in   internal divide ratio (0 and 1 both give one tick per cycle)
//   rtc_i       in   asynchronous external RTC square wave
//   tmo_i       in   watchdog timeout in cycles, 0 disables the watchdog
//   lost_clr_i  in   clears rtc_lost_o and the watchdog counter
//   tick_o      out  registered one-cycle increment pulse
//   rtc_lost_o  out  sticky "external RTC stalled" flag
// -----------------------------------------------------------------------------
module iob_clint_rtc_tick #(
  parameter int DIV_W    = 16,
  parameter int SYNC_W   = 2,
  parameter int FILT_LEN = 4,
  parameter int TMO_W    = 20
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             en_i,
  input  logic             src_sel_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             rtc_i,
  input  logic [TMO_W-1:0] tmo_i,
  input  logic             lost_clr_i,
  output logic             tick_o,
  output logic             rtc_lost_o
);

  if (SYNC_W < 2) begin : g_bad_sync_w
    $error("iob_clint_rtc_tick: SYNC_W must be 2 or more");
  end
  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("iob_clint_rtc_tick: FILT_LEN must be 1 or more");
  end

  // ---------------------------------------------------------------------------
  // Stage 0: synchronizer chain and priming tracker
  // ---------------------------------------------------------------------------
  // prime_q fills with ones in step with sync_q. Its top bit says that rtc_s
  // holds a real sample of rtc_i and not the reset value.
  logic [SYNC_W-1:0] sync_q, sync_d;
  logic [SYNC_W-1:0] prime_q, prime_d;
  logic              rtc_s;
  logic              primed;

  always_comb begin
    sync_d  = {sync_q[SYNC_W-2:0], rtc_i};
    prime_d = {prime_q[SYNC_W-2:0], 1'b1};
  end

  assign rtc_s  = sync_q[SYNC_W-1];
  assign primed = prime_q[SYNC_W-1];

  // ---------------------------------------------------------------------------
  // Stage 1: optional glitch filter, which produces rtc_f
  // ---------------------------------------------------------------------------
  logic rtc_f;

`ifdef IOB_CLINT_RTC_FILTER_EN
  localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [FC_W-1:0] filt_cnt_q, filt_cnt_d;
  logic            rtc_f_q, rtc_f_d;

  // rtc_f follows rtc_s only after rtc_s has differed for FILT_LEN cycles in
  // a row. Agreement between the two resets the count.
  always_comb begin
    filt_cnt_d = '0;
    rtc_f_d    = rtc_f_q;
    if (rtc_s != rtc_f_q) begin
      if (filt_cnt_q == FC_W'(FILT_LEN - 1)) begin
        rtc_f_d = rtc_s;
      end else begin
        filt_cnt_d = filt_cnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      filt_cnt_q <= '0;
      rtc_f_q    <= 1'b0;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      rtc_f_q    <= rtc_f_d;
    end
  end

  assign rtc_f = rtc_f_q;
`else
  assign rtc_f = rtc_s;
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: edge detect, divider, watchdog, which feed the output registers
  // ---------------------------------------------------------------------------
  logic             rtc_d_q, rtc_d_d;
  logic             arm_q, arm_d;
  logic             rise;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             div_sel;
  logic             hit;
  logic [TMO_W-1:0] lost_cnt_q, lost_cnt_d;
  logic             wd_act;
  logic             lost_set;
  logic             tick_q, tick_d;
  logic             rtc_lost_q, rtc_lost_d;

  // Edges are accepted only after the filtered level has been seen truly low
  // since reset. The 0 -> 1 step that appears when a high rtc_i first
  // reaches the chain after reset release therefore gives no tick.
  always_comb begin
    rtc_d_d = rtc_f;
    arm_d   = arm_q | (primed & ~rtc_s & ~rtc_f);
    rise    = arm_q & rtc_f & ~rtc_d_q;
  end

  // The >= compare also catches a div_i lowered below the running count.
  always_comb begin
    div_sel   = en_i & src_sel_i;
    hit       = (div_i <= DIV_W'(1)) | (div_cnt_q >= (div_i - DIV_W'(1)));
    div_cnt_d = '0;
    if (div_sel && !hit) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_comb begin
    wd_act     = en_i & ~src_sel_i & (tmo_i != '0);
    lost_cnt_d = lost_cnt_q;
    if (!wd_act || lost_clr_i || rise) begin
      lost_cnt_d = '0;
    end else if (!(&lost_cnt_q)) begin
      lost_cnt_d = lost_cnt_q + TMO_W'(1);
    end
    lost_set   = wd_act & ~rise & (lost_cnt_q == (tmo_i - TMO_W'(1)));
    // A clear overrides a set in the same cycle.
    rtc_lost_d = lost_clr_i ? 1'b0 : (rtc_lost_q | lost_set);
  end

  // Only the currently selected source can produce a tick. A rise from the
  // other source in a switch cycle is dropped.
  always_comb begin
    tick_d = en_i & (src_sel_i ? hit : rise);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q     <= '0;
      prime_q    <= '0;
      rtc_d_q    <= 1'b0;
      arm_q      <= 1'b0;
      div_cnt_q  <= '0;
      lost_cnt_q <= '0;
      tick_q     <= 1'b0;
      rtc_lost_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prime_q    <= prime_d;
      rtc_d_q    <= rtc_d_d;
      arm_q      <= arm_d;
      div_cnt_q  <= div_cnt_d;
      lost_cnt_q <= lost_cnt_d;
      tick_q     <= tick_d;
      rtc_lost_q <= rtc_lost_d;
    end
  end

  assign tick_o     = tick_q;
  assign rtc_lost_o = rtc_lost_q;

endmodule

// File: tb/tb_iob_clint_rtc_tick.sv
// -----------------------------------------------------------------------------
// Testbench for iob_clint_rtc_tick: directed scenarios, each with expected
// values worked out by hand. The latency and glitch expectations follow
// IOB_CLINT_RTC_FILTER_EN.
// -----------------------------------------------------------------------------
module tb_iob_clint_rtc_tick;

  localparam int DIV_W    = 16;
  localparam int SYNC_W   = 2;
  localparam int FILT_LEN = 4;
  localparam int TMO_W    = 20;
`ifdef IOB_CLINT_RTC_FILTER_EN
  localparam int LAT          = SYNC_W + FILT_LEN + 1;
  localparam int GLITCH_TICKS = 0;
`else
  localparam int LAT          = SYNC_W + 1;
  localparam int GLITCH_TICKS = 1;
`endif

  logic             clk = 1'b0;
  logic             arst_n;
  logic             en;
  logic             src_sel;
  logic [DIV_W-1:0] div;
  logic             rtc;
  logic [TMO_W-1:0] tmo;
  logic             lost_clr;
  logic             tick;
  logic             lost;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iob_clint_rtc_tick #(
    .DIV_W   (DIV_W),
    .SYNC_W  (SYNC_W),
    .FILT_LEN(FILT_LEN),
    .TMO_W   (TMO_W)
  ) dut (
    .clk_i     (clk),
    .arst_n_i  (arst_n),
    .en_i      (en),
    .src_sel_i (src_sel),
    .div_i     (div),
    .rtc_i     (rtc),
    .tmo_i     (tmo),
    .lost_clr_i(lost_clr),
    .tick_o    (tick),
    .rtc_lost_o(lost)
  );

  // Advance n rising edges. Outputs are sampled 1 ns after each edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    arst_n   = 1'b0;
    en       = 1'b0;
    src_sel  = 1'b0;
    div      = '0;
    rtc      = 1'b0;
    tmo      = '0;
    lost_clr = 1'b0;
    cyc(3);
    arst_n = 1'b1;
    cyc(5);
  endtask

  task automatic test_reset;
    int bad;
    int ticks;
    int first;
    do_reset();
    en = 1'b1; src_sel = 1'b1; div = '0;
    cyc(2);
    n_cmp++;
    if (tick !== 1'b1) $display("FAIL reset_pre_tick: got %b want 1", tick);
    if (tick !== 1'b1) n_fail++;
    #2 arst_n = 1'b0;
    #1;
    n_cmp++;
    if (tick !== 1'b0 || lost !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: tick=%b lost=%b want 0/0", tick, lost);
    end
    bad = 0;
    src_sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rtc = ~rtc;
      cyc(1);
      if (tick !== 1'b0 || lost !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_hold: %0d cycles with nonzero outputs, want 0", bad);
    end
    rtc = 1'b1;
    arst_n = 1'b1;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (tick === 1'b1) ticks++;
    end
    n_cmp++;
    if (ticks != 0) begin
      n_fail++;
      $display("FAIL reset_release_high: ticks=%0d want 0", ticks);
    end
    rtc = 1'b0;
    cyc(LAT + 4);
    rtc = 1'b1;
    ticks = 0; first = -1;
    for (int i = 1; i <= LAT + 6; i++) begin
      cyc(1);
      if (tick === 1'b1) begin
        ticks++;
        if (first < 0) first = i;
      end
    end
    n_cmp++;
    if (ticks != 1 || first != LAT) begin
      n_fail++;
      $display("FAIL reset_first_rise: ticks=%0d at %0d want 1 at %0d", ticks, first, LAT);
    end
  endtask

  task automatic test_external;
    int ticks;
    int first;
    do_reset();
    en = 1'b1; src_sel = 1'b0;
    cyc(5);
    for (int r = 0; r < 10; r++) begin
      rtc = 1'b1; ticks = 0; first = -1;
      for (int i = 1; i <= 500; i++) begin
        cyc(1);
        if (tick === 1'b1) begin
          ticks++;
          if (first < 0) first = i;
        end
      end
      rtc = 1'b0;
      for (int i = 1; i <= 500; i++) begin
        cyc(1);
        if (tick === 1'b1) ticks++;
      end
      n_cmp++;
      if (ticks != 1) begin
        n_fail++;
        $display("FAIL ext_count[%0d]: ticks=%0d want 1", r, ticks);
      end
      n_cmp++;
      if (first != LAT) begin
        n_fail++;
        $display("FAIL ext_latency[%0d]: got %0d want %0d", r, first, LAT);
      end
    end
  endtask

  task automatic test_divider;
    int bad;
    logic exp;
    do_reset();
    src_sel = 1'b1; div = 16'd5; en = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      exp = ((i % 5) == 4);
      if (tick !== exp) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL div5: %0d wrong cycles, want 0", bad);
    end
    div = 16'd0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (tick !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL div0: %0d cycles without tick, want 0", bad);
    end
    en = 1'b0;
    cyc(2);
    div = 16'd10; en = 1'b1;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      if (tick !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL div10_run: %0d early ticks, want 0", bad);
    end
    div = 16'd3;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      exp = ((i % 3) == 0);
      if (tick !== exp) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL div_lower: %0d wrong cycles, want 0", bad);
    end
  endtask

  task automatic test_watchdog;
    int first;
    int bad;
    int ticks;
    do_reset();
    src_sel = 1'b0; tmo = 20'd50; en = 1'b1;
    first = -1;
    for (int i = 1; i <= 60; i++) begin
      cyc(1);
      if (lost === 1'b1 && first < 0) first = i;
    end
    n_cmp++;
    if (first != 50) begin
      n_fail++;
      $display("FAIL wd_timeout: set at %0d want 50", first);
    end
    n_cmp++;
    if (lost !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_sticky: got %b want 1", lost);
    end
    lost_clr = 1'b1;
    cyc(1);
    lost_clr = 1'b0;
    n_cmp++;
    if (lost !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_clear: got %b want 0", lost);
    end
    cyc(49);
    lost_clr = 1'b1;
    cyc(1);
    lost_clr = 1'b0;
    n_cmp++;
    if (lost !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_clr_wins: got %b want 0", lost);
    end
    first = -1;
    for (int i = 1; i <= 55; i++) begin
      cyc(1);
      if (lost === 1'b1 && first < 0) first = i;
    end
    n_cmp++;
    if (first != 50) begin
      n_fail++;
      $display("FAIL wd_after_clr: set at %0d want 50", first);
    end
    do_reset();
    src_sel = 1'b0; tmo = 20'd50; en = 1'b1;
    bad = 0; ticks = 0;
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 40; i++) begin
        rtc = (i >= 20);
        cyc(1);
        if (lost !== 1'b0) bad++;
        if (tick === 1'b1) ticks++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wd_alive: flag high %0d cycles, want 0", bad);
    end
    n_cmp++;
    if (ticks < 9 || ticks > 10) begin
      n_fail++;
      $display("FAIL wd_alive_ticks: got %0d want 9..10", ticks);
    end
  endtask

  task automatic test_filter;
    int ticks;
    int first;
    do_reset();
    en = 1'b1; src_sel = 1'b0;
    cyc(5);
    rtc = 1'b1;
    cyc(2);
    rtc = 1'b0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (tick === 1'b1) ticks++;
    end
    n_cmp++;
    if (ticks != GLITCH_TICKS) begin
      n_fail++;
      $display("FAIL filt_glitch: ticks=%0d want %0d", ticks, GLITCH_TICKS);
    end
    rtc = 1'b1;
    ticks = 0; first = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (i == 6) rtc = 1'b0;
      if (tick === 1'b1) begin
        ticks++;
        if (first < 0) first = i;
      end
    end
    n_cmp++;
    if (ticks != 1 || first != LAT) begin
      n_fail++;
      $display("FAIL filt_pulse6: ticks=%0d at %0d want 1 at %0d", ticks, first, LAT);
    end
  endtask

  task automatic test_enable_switch;
    int ticks;
    int first;
    int bad;
    logic exp;
    do_reset();
    src_sel = 1'b0;
    rtc = 1'b1;
    cyc(LAT + 5);
    en = 1'b1;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (tick === 1'b1) ticks++;
    end
    n_cmp++;
    if (ticks != 0) begin
      n_fail++;
      $display("FAIL en_while_high: ticks=%0d want 0", ticks);
    end
    rtc = 1'b0;
    cyc(LAT + 5);
    rtc = 1'b1;
    ticks = 0; first = -1;
    for (int i = 1; i <= LAT + 5; i++) begin
      cyc(1);
      if (tick === 1'b1) begin
        ticks++;
        if (first < 0) first = i;
      end
    end
    n_cmp++;
    if (ticks != 1 || first != LAT) begin
      n_fail++;
      $display("FAIL en_next_rise: ticks=%0d at %0d want 1 at %0d", ticks, first, LAT);
    end
    rtc = 1'b0;
    cyc(LAT + 5);
    rtc = 1'b1;
    cyc(LAT - 1);
    src_sel = 1'b1; div = 16'd7;
    bad = 0;
    for (int i = 1; i <= 14; i++) begin
      cyc(1);
      exp = (i == 7) || (i == 14);
      if (tick !== exp) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL src_switch: %0d wrong cycles, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_external();
    test_divider();
    test_watchdog();
    test_filter();
    test_enable_switch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
